pool_win_buf: RTL and testbench



---
 rtl/cnn_pkg.sv | 22 ++
 rtl/pool_win_ram.sv | 68 ++++++
 rtl/pool_win_buf.sv | 160 ++++++++++++++++
 tb/tb_pool_win_buf.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types and elaboration-time helpers for the CNN pooling/window stages.
//   data_t  : signed sample word at the default data width
//   addr_w  : pointer width able to count 0..w*h inclusive
//   br0     : bottom-right tap address of the first KxK window in a w-wide map
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DW_DEF = 18;

    typedef logic signed [DW_DEF-1:0] data_t;

    function automatic int addr_w(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    function automatic int br0(input int w, input int k);
        return (k - 1) * w + (k - 1);
    endfunction

endpackage

// File: rtl/pool_win_ram.sv
// -----------------------------------------------------------------------------
// pool_win_ram
// Single-channel pooled-map storage (MAP_W*MAP_H words) with one write port and
// a registered KxK window read whose bottom-right tap sits at raddr_i.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the tap registers)
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : signed write data
//   raddr_i    : bottom-right tap address of the requested window
//   taps_o     : window taps, taps_o[i*K+j] = word at raddr_i-(K-1-i)*MAP_W-(K-1-j)
// -----------------------------------------------------------------------------
module pool_win_ram
    import cnn_pkg::*;
#(
    parameter int DW    = 18,
    parameter int MAP_W = 13,
    parameter int MAP_H = 13,
    parameter int K     = 3,
    parameter int AW    = addr_w(MAP_W, MAP_H)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [AW-1:0]             waddr_i,
    input  logic signed [DW-1:0]      wdata_i,
    input  logic [AW-1:0]             raddr_i,
    output logic [K*K-1:0][DW-1:0]    taps_o
);

    localparam int DEPTH = MAP_W * MAP_H;

    logic [DW-1:0]          mem_q [DEPTH];
    logic [K*K-1:0][AW-1:0] tap_addr;
    logic [K*K-1:0][DW-1:0] taps_d;
    logic [K*K-1:0][DW-1:0] taps_q;

    // Storage is not reset; a frame clear only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read pointer never goes below the first window's bottom-right tap,
    // so every tap address stays inside the map.
    always_comb begin
        tap_addr = '0;
        taps_d   = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                tap_addr[i*K+j] = raddr_i - AW'((K - 1 - i) * MAP_W + (K - 1 - j));
                taps_d[i*K+j]   = mem_q[tap_addr[i*K+j]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/pool_win_buf.sv
// -----------------------------------------------------------------------------
// pool_win_buf
// 2x2 signed max-pool (optional ReLU) on NCH channels into a MAP_W x MAP_H
// buffer per channel, serving KxK stride-1 windows to the next conv stage.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   strt        : din holds one 2x2 pool group per channel; write it
//   din         : [NCH][4] signed pool candidates
//   tx_done     : frame clear, rewinds all pointers (buffer contents kept)
//   addr_rd_inc : consumer advances to the next window (accepted only when rd)
//   rd          : current window fully written and frame not finished
//   win_vld     : dout holds the current window
//   dout        : [NCH*K*K] window taps, index ch*K*K + i*K + j
//   wr_full     : all MAP_W*MAP_H pixels written
//   frame_done  : last window consumed
// -----------------------------------------------------------------------------
module pool_win_buf
    import cnn_pkg::*;
#(
    parameter int DW    = 18,
    parameter int NCH   = 2,
    parameter int MAP_W = 13,
    parameter int MAP_H = 13,
    parameter int K     = 3,
    parameter int RELU  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          strt,
    input  logic [NCH-1:0][3:0][DW-1:0]   din,
    input  logic                          tx_done,
    input  logic                          addr_rd_inc,
    output logic                          rd,
    output logic                          win_vld,
    output logic [NCH*K*K-1:0][DW-1:0]    dout,
    output logic                          wr_full,
    output logic                          frame_done
);

    localparam int            AW       = addr_w(MAP_W, MAP_H);
    localparam int            CW       = $clog2(MAP_W + 1);
    localparam int            RW       = $clog2(MAP_H + 1);
    localparam logic [AW-1:0] NPIX     = AW'(MAP_W * MAP_H);
    localparam logic [AW-1:0] BR0_A    = AW'(br0(MAP_W, K));
    localparam logic [CW-1:0] COL_LAST = CW'(MAP_W - K);
    localparam logic [RW-1:0] ROW_LAST = RW'(MAP_H - K);

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    // Two-level max tree; the result is always one of the candidates (or 0
    // under ReLU), so no width growth is needed.
    function automatic logic signed [DW-1:0] pool4(input logic [3:0][DW-1:0] c);
        logic signed [DW-1:0] m;
        m = smax(smax(c[0], c[1]), smax(c[2], c[3]));
        if (RELU != 0 && m < 0) begin
            m = '0;
        end
        return m;
    endfunction

    logic [AW-1:0] addr_wr_q, addr_wr_d;
    logic [AW-1:0] addr_rd_q, addr_rd_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          frame_done_q, frame_done_d;
    logic          win_vld_q, win_vld_d;
    logic          we;
    logic          inc_acc;

    logic signed [DW-1:0] pooled [NCH];

    assign wr_full = (addr_wr_q == NPIX);
    assign rd      = (addr_rd_q < addr_wr_q) & ~frame_done_q;
    // A frame clear in the same cycle drops the write.
    assign we      = strt & ~wr_full & ~tx_done;
    assign inc_acc = addr_rd_inc & rd;

    always_comb begin
        addr_wr_d    = addr_wr_q;
        addr_rd_d    = addr_rd_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = frame_done_q;
        // dout only tracks addr_rd when the pointer is not moving this cycle.
        win_vld_d    = rd & ~addr_rd_inc;

        if (tx_done) begin
            addr_wr_d    = '0;
            addr_rd_d    = BR0_A;
            col_d        = '0;
            row_d        = '0;
            frame_done_d = 1'b0;
            win_vld_d    = 1'b0;
        end else begin
            if (we) begin
                addr_wr_d = addr_wr_q + AW'(1);
            end
            if (inc_acc) begin
                if (col_q == COL_LAST) begin
                    if (row_q == ROW_LAST) begin
                        // Last window consumed: pointers hold on it.
                        frame_done_d = 1'b1;
                    end else begin
                        col_d     = '0;
                        row_d     = row_q + RW'(1);
                        addr_rd_d = addr_rd_q + AW'(K);
                    end
                end else begin
                    col_d     = col_q + CW'(1);
                    addr_rd_d = addr_rd_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_wr_q    <= '0;
            addr_rd_q    <= BR0_A;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            win_vld_q    <= 1'b0;
        end else begin
            addr_wr_q    <= addr_wr_d;
            addr_rd_q    <= addr_rd_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            win_vld_q    <= win_vld_d;
        end
    end

    assign frame_done = frame_done_q;
    assign win_vld    = win_vld_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign pooled[g] = pool4(din[g]);

        pool_win_ram #(
            .DW    (DW),
            .MAP_W (MAP_W),
            .MAP_H (MAP_H),
            .K     (K),
            .AW    (AW)
        ) u_ram (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (we),
            .waddr_i (addr_wr_q),
            .wdata_i (pooled[g]),
            .raddr_i (addr_rd_q),
            .taps_o  (dout[g*K*K +: K*K])
        );
    end

endmodule

// File: tb/tb_pool_win_buf.sv
module tb_pool_win_buf;

    localparam int DW   = 18;
    localparam int NCH  = 2;
    localparam int MW   = 13;
    localparam int MH   = 13;
    localparam int K    = 3;
    localparam int KK   = K * K;
    localparam int NPIX = MW * MH;
    localparam int BR0  = (K - 1) * MW + K - 1;

    typedef logic [NCH*KK-1:0][DW-1:0] win_t;
    typedef struct {
        win_t n;
        win_t r;
    } exp_t;

    logic                        clk;
    logic                        rst_n;
    logic                        strt;
    logic [NCH-1:0][3:0][DW-1:0] din;
    logic                        tx_done;
    logic                        addr_rd_inc;
    logic                        rd, win_vld, wr_full, frame_done;
    win_t                        dout;
    logic                        rd_r, win_vld_r, wr_full_r, frame_done_r;
    win_t                        dout_r;

    pool_win_buf #(.DW(DW), .NCH(NCH), .MAP_W(MW), .MAP_H(MH), .K(K), .RELU(0)) dut (
        .clk(clk), .rst_n(rst_n), .strt(strt), .din(din), .tx_done(tx_done),
        .addr_rd_inc(addr_rd_inc), .rd(rd), .win_vld(win_vld), .dout(dout),
        .wr_full(wr_full), .frame_done(frame_done)
    );

    pool_win_buf #(.DW(DW), .NCH(NCH), .MAP_W(MW), .MAP_H(MH), .K(K), .RELU(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .strt(strt), .din(din), .tx_done(tx_done),
        .addr_rd_inc(addr_rd_inc), .rd(rd_r), .win_vld(win_vld_r), .dout(dout_r),
        .wr_full(wr_full_r), .frame_done(frame_done_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   mm [NCH][NPIX];
    int   mr [NCH][NPIX];
    int   m_aw, m_ar, m_row, m_col;
    bit   m_fd;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input win_t obs, input win_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic win_t build(input bit relu, input int a);
        win_t w;
        w = '0;
        for (int ch = 0; ch < NCH; ch++)
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) begin
                    int idx;
                    idx = a - (K - 1 - i) * MW - (K - 1 - j);
                    w[ch*KK + i*K + j] = relu ? DW'(mr[ch][idx]) : DW'(mm[ch][idx]);
                end
        return w;
    endfunction

    // Candidates v, v-1, v-2, v-3 rotated so the max lands in different slots.
    task automatic set_din(input int v0, input int v1, input int rot);
        for (int k = 0; k < 4; k++) begin
            din[0][k] = DW'(v0 - ((k + rot) % 4));
            din[1][k] = DW'(v1 - ((k + rot + 1) % 4));
        end
    endtask

    // Drive one cycle and advance the reference model by the specified rules.
    task automatic step(input bit s, input bit inc, input bit txd, input int e0, input int e1);
        bit mrd;
        mrd = (m_ar < m_aw) && !m_fd;
        if (txd) begin
            m_aw = 0; m_ar = BR0; m_row = 0; m_col = 0; m_fd = 1'b0;
        end else begin
            if (s && m_aw < NPIX) begin
                mm[0][m_aw] = e0;
                mm[1][m_aw] = e1;
                mr[0][m_aw] = (e0 < 0) ? 0 : e0;
                mr[1][m_aw] = (e1 < 0) ? 0 : e1;
                m_aw++;
            end
            if (inc && mrd) begin
                if (m_col == MW - K) begin
                    if (m_row == MH - K) m_fd = 1'b1;
                    else begin m_col = 0; m_row++; m_ar += K; end
                end else begin
                    m_col++; m_ar++;
                end
            end
        end
        strt = s; addr_rd_inc = inc; tx_done = txd;
        @(posedge clk);
        #1;
        strt = 1'b0; addr_rd_inc = 1'b0; tx_done = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic wr_val(input int v);
        set_din(v, -v, v % 4);
        step(1'b1, 1'b0, 1'b0, v, -v);
    endtask

    task automatic expect_win();
        exp_t e;
        e.n = build(1'b0, m_ar);
        e.r = build(1'b1, m_ar);
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_win(tag, dout, e.n);
            chk_win({tag, "_relu"}, dout_r, e.r);
        end
    endtask

    task automatic wait_win(input string tag);
        int t;
        t = 0;
        while (win_vld !== 1'b1 && t < 8) begin
            idle();
            t++;
        end
        chk({tag, "_vld"}, win_vld, 1);
        chk({tag, "_vld_relu"}, win_vld_r, 1);
        pop_cmp(tag);
    endtask

    initial begin
        rst_n = 1'b0; strt = 1'b0; tx_done = 1'b0; addr_rd_inc = 1'b0; din = '0;
        m_aw = 0; m_ar = BR0; m_row = 0; m_col = 0; m_fd = 1'b0;
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < NPIX; a++) begin mm[c][a] = 0; mr[c][a] = 0; end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", rd, 0);
        chk("rst_win_vld", win_vld, 0);
        chk("rst_wr_full", wr_full, 0);
        chk("rst_frame_done", frame_done, 0);
        chk_win("rst_dout", dout, '0);
        rst_n = 1'b1;
        idle();

        // Ramp frame: 28 writes leave the first window incomplete.
        for (int n = 0; n < 28; n++) wr_val(n);
        chk("rd_after_28", rd, 0);
        wr_val(28);
        chk("rd_after_29", rd, 1);
        chk("vld_same_cycle", win_vld, 0);
        expect_win();
        idle();
        chk("vld_next_cycle", win_vld, 1);
        wait_win("win_first");

        // Accepted inc to 29 leaves the window incomplete; a second inc is ignored.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("rd_after_inc", rd, 0);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("rd_ign_inc", rd, 0);
        for (int n = 29; n < 42; n++) wr_val(n);
        expect_win();
        wait_win("win_29");

        // Ten more accepted incs: 11 in total, column wrap to row 1 (addr 41).
        for (int n = 0; n < 10; n++) step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("rd_row1", rd, 1);
        expect_win();
        wait_win("win_41");

        for (int n = 42; n < 168; n++) wr_val(n);
        chk("wr_full_168", wr_full, 0);
        wr_val(168);
        chk("wr_full_169", wr_full, 1);

        for (int n = 0; n < 109; n++) step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("fd_before_last", frame_done, 0);
        expect_win();
        wait_win("win_last");
        step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("fd_last", frame_done, 1);
        chk("rd_fd", rd, 0);
        chk("wr_full_fd", wr_full, 1);

        // Writes and incs after the frame completes change nothing.
        set_din(999, 999, 0);
        step(1'b1, 1'b0, 1'b0, 999, 999);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 1'b0, 0, 0);
        expect_win();
        idle();
        chk("fd_hold", frame_done, 1);
        chk("vld_hold", win_vld, 0);
        pop_cmp("win_hold");

        step(1'b0, 1'b0, 1'b1, 0, 0);
        chk("tx_rd", rd, 0);
        chk("tx_wr_full", wr_full, 0);
        chk("tx_fd", frame_done, 0);
        chk("tx_vld", win_vld, 0);

        // Frame 2: explicit pooling patterns at address 0.
        din[0][0] = DW'(-5); din[0][1] = DW'(3);  din[0][2] = DW'(-7); din[0][3] = DW'(2);
        din[1][0] = DW'(-1); din[1][1] = DW'(-2); din[1][2] = DW'(-3); din[1][3] = DW'(-4);
        step(1'b1, 1'b0, 1'b0, 3, -1);
        for (int n = 1; n < 28; n++) wr_val(n + 500);
        chk("f2_rd_28", rd, 0);
        wr_val(528);
        chk("f2_rd_29", rd, 1);
        expect_win();
        wait_win("win_pool");
        chk("pool_max", $signed(dout[0]), 3);
        chk("pool_neg", $signed(dout[KK]), -1);
        chk("pool_max_relu", $signed(dout_r[0]), 3);
        chk("pool_neg_relu", $signed(dout_r[KK]), 0);

        // Frame clear together with strt and inc: strt dropped, pointers rewound.
        set_din(777, 777, 0);
        step(1'b1, 1'b1, 1'b1, 777, 777);
        chk("txs_rd", rd, 0);
        chk("txs_wr_full", wr_full, 0);
        chk("txs_vld", win_vld, 0);
        for (int n = 0; n < 28; n++) wr_val(n + 2000);
        chk("f3_rd_28", rd, 0);
        wr_val(2028);
        chk("f3_rd_29", rd, 1);
        expect_win();
        wait_win("win_f3");
        step(1'b0, 1'b1, 1'b0, 0, 0);
        idle();
        expect_win();
        idle();
        pop_cmp("win_nowrite");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
